// File: rtl/motor_pkg.sv
// ----------------------------------------------------------------------------
// motor_pkg
//  Shared types and constants for the dual H-bridge PWM driver.
//  motor_cmd_t  : sign-magnitude motor command, [7]=dir (0 fwd, 1 rev), [6:0]=duty
//  chan_state_t : per-channel bridge state (IDLE / RUN / DEAD)
//  PWM_TOP      : last value of the PWM counter before it wraps to 0
// ----------------------------------------------------------------------------
package motor_pkg;

   typedef struct packed {
      logic       dir;
      logic [6:0] duty;
   } motor_cmd_t;

   typedef enum logic [1:0] {IDLE, RUN, DEAD} chan_state_t;

   localparam logic [6:0] PWM_TOP = 7'd126;

endpackage : motor_pkg

// File: rtl/pwm_channel.sv
// ----------------------------------------------------------------------------
// pwm_channel
//  One H-bridge channel: state machine, dead-time counter and registered pin
//  drivers. All state changes happen on the PWM wrap and use the direction
//  being loaded into the active command at that same wrap.
// Parameters
//  DEAD_PERIODS : whole PWM periods the bridge coasts on a direction reversal
// Ports
//  clk, reset   : clock, asynchronous active-low reset
//  cnt          : shared PWM counter 0..126
//  wrap         : one-clk strobe on the last clk of each PWM period
//  duty         : duty of the currently active command
//  next_dir     : direction of the command taking effect at this wrap
//  armed        : a command has been received since reset / watchdog trip
//  force_idle   : synchronous return to IDLE (watchdog trip)
//  en           : PWM enable pin (registered)
//  a_fwd, a_rev : direction pins (registered), both 0 unless running
// ----------------------------------------------------------------------------
module pwm_channel
   import motor_pkg::*;
#(
   parameter int DEAD_PERIODS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] cnt,
   input  logic       wrap,
   input  logic [6:0] duty,
   input  logic       next_dir,
   input  logic       armed,
   input  logic       force_idle,
   output logic       en,
   output logic       a_fwd,
   output logic       a_rev
);

   localparam int DW = (DEAD_PERIODS > 1) ? $clog2(DEAD_PERIODS) : 1;

   chan_state_t   state;
   logic          dir;
   logic [DW-1:0] dcnt;

   // NOTE: every register here uses non-blocking assignment so all of them
   // sample the same pre-edge values of state, dir and cnt.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         dir   <= 1'b0;
         dcnt  <= '0;
         en    <= 1'b0;
         a_fwd <= 1'b0;
         a_rev <= 1'b0;
      end else begin
         // Pins are registered from the current state, so they trail the
         // counter by one clk and never glitch within a period.
         en    <= (state == RUN) && (cnt < duty);
         a_fwd <= (state == RUN) && !dir;
         a_rev <= (state == RUN) && dir;

         if (force_idle) begin
            state <= IDLE;
            dcnt  <= '0;
         end else if (wrap) begin
            unique case (state)
               IDLE: begin
                  if (armed) begin
                     dir   <= next_dir;
                     state <= RUN;
                  end
               end
               RUN: begin
                  if (next_dir != dir) begin
                     state <= DEAD;
                     dcnt  <= '0;
                  end
               end
               DEAD: begin
                  // Dead time always runs to completion; the direction is
                  // only re-sampled once it has elapsed.
                  if (dcnt == DW'(DEAD_PERIODS - 1)) begin
                     dir   <= next_dir;
                     state <= RUN;
                  end else begin
                     dcnt <= dcnt + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule : pwm_channel

// File: rtl/motor_pwm_driver.sv
// ----------------------------------------------------------------------------
// motor_pwm_driver
//  Dual H-bridge driver fed by two sign-magnitude motor commands. Commands
//  are captured into shadow registers on cmd_valid and moved to the active
//  registers only at a PWM period boundary (wrap). A command arriving in the
//  wrap cycle itself bypasses the shadow and is used for the new period.
//  Optional watchdog: define MOTOR_WATCHDOG_EN to stop both channels after
//  WD_PERIODS periods without a command.
// Parameters
//  PRESCALE     : clk cycles per PWM count (period = PRESCALE*127 clk)
//  DEAD_PERIODS : periods a channel coasts on a direction reversal
//  WD_PERIODS   : watchdog timeout in periods (MOTOR_WATCHDOG_EN only)
// Ports
//  clk, reset         : clock, asynchronous active-low reset
//  motor1, motor2     : channel commands, [7]=dir, [6:0]=duty
//  cmd_valid          : one-clk strobe, motor1/motor2 valid
//  enable12, enable34 : channel PWM enables
//  a1/a2, a3/a4       : channel direction pins (fwd 1/0, rev 0/1)
//  wd_tripped         : watchdog tripped flag (0 without the watchdog)
// ----------------------------------------------------------------------------
module motor_pwm_driver
   import motor_pkg::*;
#(
   parameter int PRESCALE     = 24,
   parameter int DEAD_PERIODS = 2
`ifdef MOTOR_WATCHDOG_EN
  ,parameter int WD_PERIODS   = 200
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] motor1,
   input  logic [7:0] motor2,
   input  logic       cmd_valid,
   output logic       enable12,
   output logic       enable34,
   output logic       a1,
   output logic       a2,
   output logic       a3,
   output logic       a4,
   output logic       wd_tripped
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PW-1:0] pre;
   logic [6:0]    cnt;
   logic          tick, wrap;
   motor_cmd_t    shadow1, shadow2, next1, next2;
   logic [6:0]    duty1, duty2;
   logic          armed, armed_eff, trip_now, force_idle;

   assign tick = (pre == PW'(PRESCALE - 1));
   assign wrap = tick && (cnt == PWM_TOP);

   // Command used for the coming period: a same-cycle cmd_valid wins.
   assign next1 = cmd_valid ? motor_cmd_t'(motor1) : shadow1;
   assign next2 = cmd_valid ? motor_cmd_t'(motor2) : shadow2;

   // A command in the wrap cycle must start the channels at that very wrap.
   assign armed_eff = armed | cmd_valid;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre     <= '0;
         cnt     <= '0;
         shadow1 <= '0;
         shadow2 <= '0;
         duty1   <= '0;
         duty2   <= '0;
         armed   <= 1'b0;
      end else begin
         pre <= tick ? '0 : pre + 1'b1;
         if (tick) cnt <= (cnt == PWM_TOP) ? 7'd0 : cnt + 7'd1;
         if (cmd_valid) begin
            shadow1 <= motor_cmd_t'(motor1);
            shadow2 <= motor_cmd_t'(motor2);
         end
         // Only the duty is kept here; the applied direction lives in each
         // channel, which latches it at the same wrap.
         if (wrap) begin
            duty1 <= next1.duty;
            duty2 <= next2.duty;
         end
         if (cmd_valid)     armed <= 1'b1;
         else if (trip_now) armed <= 1'b0;
      end
   end

`ifdef MOTOR_WATCHDOG_EN
   localparam int WW = $clog2(WD_PERIODS + 1);

   logic [WW-1:0] wd_cnt;
   logic          wd_q;

   // The timeout only runs while the channels are armed, so an idle bridge
   // that has never been commanded does not report a trip.
   assign trip_now   = wrap && armed && !cmd_valid && (wd_cnt == WW'(WD_PERIODS - 1));
   assign force_idle = trip_now;
   assign wd_tripped = wd_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
         wd_q   <= 1'b0;
      end else if (cmd_valid) begin
         wd_cnt <= '0;
         wd_q   <= 1'b0;
      end else if (trip_now) begin
         wd_cnt <= '0;
         wd_q   <= 1'b1;
      end else if (wrap && armed) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign trip_now   = 1'b0;
   assign force_idle = 1'b0;
   assign wd_tripped = 1'b0;
`endif

   pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_ch1 (
      .clk        (clk),
      .reset      (reset),
      .cnt        (cnt),
      .wrap       (wrap),
      .duty       (duty1),
      .next_dir   (next1.dir),
      .armed      (armed_eff),
      .force_idle (force_idle),
      .en         (enable12),
      .a_fwd      (a1),
      .a_rev      (a2)
   );

   pwm_channel #(.DEAD_PERIODS(DEAD_PERIODS)) u_ch2 (
      .clk        (clk),
      .reset      (reset),
      .cnt        (cnt),
      .wrap       (wrap),
      .duty       (duty2),
      .next_dir   (next2.dir),
      .armed      (armed_eff),
      .force_idle (force_idle),
      .en         (enable34),
      .a_fwd      (a3),
      .a_rev      (a4)
   );

endmodule : motor_pwm_driver

// File: tb/tb_motor_pwm_driver.sv
// ----------------------------------------------------------------------------
// tb_motor_pwm_driver
//  Directed bench for motor_pwm_driver with PRESCALE=2 (254-clk periods).
//  Stimulus pushes the expected per-period pin summary (enable high counts,
//  direction pins, mid-period wd_tripped) into a queue; the monitor builds the
//  same summary from the pins at every period boundary and compares.
// ----------------------------------------------------------------------------
module tb_motor_pwm_driver;

   localparam int P = 2;
   localparam int T = 127 * P;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] motor1 = 8'h00;
   logic [7:0] motor2 = 8'h00;
   logic       cmd_valid = 1'b0;
   logic       enable12, enable34, a1, a2, a3, a4, wd_tripped;

   always #5 clk = ~clk;

   motor_pwm_driver #(
      .PRESCALE     (P),
      .DEAD_PERIODS (2)
`ifdef MOTOR_WATCHDOG_EN
     ,.WD_PERIODS   (4)
`endif
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .motor1     (motor1),
      .motor2     (motor2),
      .cmd_valid  (cmd_valid),
      .enable12   (enable12),
      .enable34   (enable34),
      .a1         (a1),
      .a2         (a2),
      .a3         (a3),
      .a4         (a4),
      .wd_tripped (wd_tripped)
   );

   typedef struct {
      int         period;
      int         en12;
      int         en34;
      logic [3:0] a;
      int         wd;
   } rec_t;

   rec_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // ---------------- monitor ----------------
   // Sample s counts negedges since reset release (s=0 in the first cycle).
   // Pins are registered one clk behind the counter, so period k is seen on
   // samples k*T+1 .. (k+1)*T.
   int         s = -1;
   int         acc12 = 0, acc34 = 0, wd_mid = 0;
   logic [3:0] acc_a = 4'b0000;
   logic [3:0] cur_a;

   task automatic finalize(input int k);
      while (exp_q.size() > 0 && exp_q[0].period < k) begin
         check($sformatf("p%0d_not_observed", exp_q[0].period), k, exp_q[0].period);
         void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].period == k) begin
         rec_t e;
         e = exp_q.pop_front();
         check($sformatf("p%0d_enable12_high_clks", k), acc12, e.en12);
         check($sformatf("p%0d_enable34_high_clks", k), acc34, e.en34);
         check($sformatf("p%0d_a1a2a3a4", k), int'(acc_a), int'(e.a));
         check($sformatf("p%0d_wd_tripped", k), wd_mid, e.wd);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         s = -1; acc12 = 0; acc34 = 0; wd_mid = 0; acc_a = 4'b0000;
      end else begin
         s++;
         if (s >= 1) begin
            cur_a = {a1, a2, a3, a4};
            // 4'b1111 cannot occur on the pins; it marks a mid-period change.
            if (s % T == 1) acc_a = cur_a;
            else if (acc_a !== cur_a) acc_a = 4'b1111;
            acc12 += int'(enable12);
            acc34 += int'(enable34);
            if (s % T == T / 2) wd_mid = int'(wd_tripped);
            if (s % T == 0) begin
               finalize(s / T - 1);
               acc12 = 0;
               acc34 = 0;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   int cyc = 0;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go(input int c);
      if (c < cyc) check("stimulus_schedule", cyc, c);
      while (cyc < c) step();
   endtask

   task automatic cmd(input int c, input logic [7:0] m1, input logic [7:0] m2);
      go(c);
      motor1    = m1;
      motor2    = m2;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic expect_p(input int k, input int e12, input int e34,
                           input logic [3:0] a, input int wd);
      rec_t r;
      r.period = k; r.en12 = e12; r.en34 = e34; r.a = a; r.wd = wd;
      exp_q.push_back(r);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #2;
      reset = 1'b1;
      cyc   = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_enable12"},   int'(enable12),   0);
      check({tag, "_enable34"},   int'(enable34),   0);
      check({tag, "_a1a2a3a4"},   int'({a1, a2, a3, a4}), 0);
      check({tag, "_wd_tripped"}, int'(wd_tripped), 0);
   endtask

   int         base;
   int         b12, b34;
   logic [3:0] ba;
   logic [7:0] m2_keep;

   initial begin
      // Reset state and the idle bridge after release.
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("in_reset");
      release_reset();
      for (int k = 0; k <= 5; k++) expect_p(k, 0, 0, 4'b0000, 0);

      // First command: ch1 fwd duty 64, ch2 rev duty 127, from the next wrap.
      cmd(5 * T + 10, 8'h40, 8'hFF);
      expect_p(6, 64 * P, T, 4'b1001, 0);
      expect_p(7, 64 * P, T, 4'b1001, 0);

      // ch1 reversal: two dead periods, then rev at the same duty.
      cmd(7 * T + 10, 8'hC0, 8'hFF);
      expect_p(8,  0,      T, 4'b0001, 0);
      expect_p(9,  0,      T, 4'b0001, 0);
      expect_p(10, 64 * P, T, 4'b0101, 0);

      // Reversal, then back to the old direction during the dead time:
      // the dead time still lasts two full periods.
      cmd(10 * T + 10, 8'h40, 8'hFF);
      cmd(11 * T + 10, 8'hC0, 8'hFF);
      expect_p(11, 0,      T, 4'b0001, 0);
      expect_p(12, 0,      T, 4'b0001, 0);
      expect_p(13, 64 * P, T, 4'b0101, 0);

      // Both channels reverse to fwd; ch1 duty 0 then 127 with no dead time.
      cmd(13 * T + 10, 8'h00, 8'h7F);
      expect_p(14, 0, 0, 4'b0000, 0);
      expect_p(15, 0, 0, 4'b0000, 0);
      expect_p(16, 0, T, 4'b1010, 0);
      cmd(16 * T + 10, 8'h7F, 8'h7F);
      expect_p(17, T, T, 4'b1010, 0);

      // Command in the wrap cycle itself: duty 16 applies immediately.
      cmd(18 * T - 1, 8'h7F, 8'h10);
      expect_p(18, T, 16 * P, 4'b1010, 0);
      expect_p(19, T, 16 * P, 4'b1010, 0);

`ifdef MOTOR_WATCHDOG_EN
      // Four wraps without a command trip the watchdog.
      expect_p(20, T, 16 * P, 4'b1010, 0);
      expect_p(21, T, 16 * P, 4'b1010, 0);
      expect_p(22, 0, 0, 4'b0000, 1);
      cmd(23 * T + 10, 8'h40, 8'hFF);
      expect_p(23, 0, 0, 4'b0000, 0);
      expect_p(24, 64 * P, T, 4'b1001, 0);
      base = 25; b12 = 64 * P; b34 = T; ba = 4'b1001; m2_keep = 8'hFF;
`else
      base = 20; b12 = T; b34 = 16 * P; ba = 4'b1010; m2_keep = 8'h10;
`endif

      // Reverse ch1, then assert reset in the middle of its dead time.
      expect_p(base, b12, b34, ba, 0);
      cmd(base * T + 10, 8'hC0, m2_keep);
      go((base + 1) * T + 100);
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("reset_mid_dead");
      check("queue_drained_before_reset", exp_q.size(), 0);
      repeat (3) @(posedge clk);
      release_reset();
      expect_p(0, 0, 0, 4'b0000, 0);
      expect_p(1, 0, 0, 4'b0000, 0);
      go(2 * T + 5);

      for (int i = 0; i < 2 * T && exp_q.size() > 0; i++) step();
      check("queue_empty_at_end", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule : tb_motor_pwm_driver
